// File: rtl/bus_cycle_stepper.sv
// bus_cycle_stepper: single/burst bus-cycle stepper for the 68000 debug path.
// Debounces the STEP switch and gates the bus-cycle enable going to DTACK
// generation: free run, one cycle per press, or BURST_IN cycles per press.
// Optional feature macro: STEPPER_BREAK_EN adds an address breakpoint that
// drops free run into paused step mode and withholds the matching cycle.
module bus_cycle_stepper #(
   parameter int DEBOUNCE_CYCLES = 4096,
   parameter int BURST_W         = 8,
   parameter int ADDR_W          = 24
) (
   input  logic               MCLK_IN,
   input  logic               RESET_IN,
   input  logic               STEPEN_IN,
   input  logic               STEP_IN,
   input  logic [BURST_W-1:0] BURST_IN,
   input  logic               ENABLE_IN,
`ifdef STEPPER_BREAK_EN
   input  logic [ADDR_W-1:0]  ADDR_IN,
   input  logic [ADDR_W-1:0]  BREAK_ADDR_IN,
   input  logic               BREAK_VALID_IN,
   output logic               BREAK_HIT_OUT,
`endif
   output logic               ENABLE_EXECUTE,
   output logic               STEP_FILTERED,
   output logic               PAUSED_OUT,
   output logic [BURST_W-1:0] CYCLES_LEFT
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_PASS = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_REL  = 2'd3;

   logic             stepen_s1, stepen_s2;
   logic             step_s1, step_s2;
   logic [CNT_W-1:0] db_cnt;
   logic             filt_prev;
   logic             en_prev;
   logic [1:0]       state;
   logic             press;
   logic             cyc_end;
   logic             break_trig;
   logic             break_latch;
   logic [BURST_W-1:0] burst_load;

   // two-flop synchronisers for the asynchronous switches
   always_ff @(posedge MCLK_IN) begin
      if (RESET_IN) begin
         stepen_s1 <= 1'b0;
         stepen_s2 <= 1'b0;
         step_s1   <= 1'b0;
         step_s2   <= 1'b0;
      end else begin
         stepen_s1 <= STEPEN_IN;
         stepen_s2 <= stepen_s1;
         step_s1   <= STEP_IN;
         step_s2   <= step_s1;
      end
   end

   // debounce: the synced level must disagree for DEBOUNCE_CYCLES samples in a row
   always_ff @(posedge MCLK_IN) begin
      if (RESET_IN) begin
         db_cnt        <= '0;
         STEP_FILTERED <= 1'b0;
      end else if (step_s2 == STEP_FILTERED) begin
         db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
         db_cnt        <= '0;
         STEP_FILTERED <= ~STEP_FILTERED;
      end else begin
         db_cnt <= db_cnt + CNT_W'(1);
      end
   end

   // previous-value registers for press and bus-cycle-end edge detection
   always_ff @(posedge MCLK_IN) begin
      if (RESET_IN) begin
         filt_prev <= 1'b0;
         en_prev   <= 1'b0;
      end else begin
         filt_prev <= STEP_FILTERED;
         en_prev   <= ENABLE_IN;
      end
   end

   assign press      = STEP_FILTERED & ~filt_prev;
   assign cyc_end    = en_prev & ~ENABLE_IN;
   assign burst_load = (BURST_IN == '0) ? BURST_W'(1) : BURST_IN;

`ifdef STEPPER_BREAK_EN
   assign break_trig = ENABLE_IN & ~en_prev & BREAK_VALID_IN & (ADDR_IN == BREAK_ADDR_IN);

   // break latch keeps us paused until a press releases the withheld cycle
   always_ff @(posedge MCLK_IN) begin
      if (RESET_IN) begin
         break_latch   <= 1'b0;
         BREAK_HIT_OUT <= 1'b0;
      end else begin
         BREAK_HIT_OUT <= (state == ST_PASS) && break_trig;
         if ((state == ST_PASS) && break_trig)
            break_latch <= 1'b1;
         else if ((state == ST_HOLD) && press)
            break_latch <= 1'b0;
      end
   end
`else
   assign break_trig  = 1'b0;
   assign break_latch = 1'b0;
`endif

   // stepper FSM: gates ENABLE_IN and tracks the remaining burst
   always_ff @(posedge MCLK_IN) begin
      if (RESET_IN) begin
         state          <= ST_PASS;
         ENABLE_EXECUTE <= 1'b0;
         CYCLES_LEFT    <= '0;
      end else begin
         case (state)
            ST_PASS: begin
               if (break_trig || stepen_s2) begin
                  state          <= ST_HOLD;
                  ENABLE_EXECUTE <= 1'b0;
               end else begin
                  ENABLE_EXECUTE <= ENABLE_IN;
               end
            end
            ST_HOLD: begin
               ENABLE_EXECUTE <= 1'b0;
               if (press) begin
                  state       <= ST_RUN;
                  CYCLES_LEFT <= burst_load;
               end else if (!stepen_s2 && !break_latch) begin
                  state <= ST_PASS;
               end
            end
            ST_RUN: begin
               ENABLE_EXECUTE <= ENABLE_IN;
               if (!stepen_s2) begin
                  // leaving step mode abandons the rest of the burst
                  state       <= ST_PASS;
                  CYCLES_LEFT <= '0;
               end else if (cyc_end && (CYCLES_LEFT != '0)) begin
                  CYCLES_LEFT <= CYCLES_LEFT - BURST_W'(1);
                  if (CYCLES_LEFT == BURST_W'(1))
                     state <= ST_REL;
               end
            end
            ST_REL: begin
               // wait for STEP release so a held press cannot re-trigger
               ENABLE_EXECUTE <= 1'b0;
               if (!STEP_FILTERED)
                  state <= (!stepen_s2 && !break_latch) ? ST_PASS : ST_HOLD;
            end
            default: begin
               state          <= ST_PASS;
               ENABLE_EXECUTE <= 1'b0;
               CYCLES_LEFT    <= '0;
            end
         endcase
      end
   end

   assign PAUSED_OUT = (state == ST_HOLD) || (state == ST_REL);

endmodule
